// File: rtl/mod47_mul_seq_if.sv
// Operand/result handshake bundle for the sequenced mod-47 multiplier.
interface mod47_mul_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a;
    logic [5:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] r;
    logic       busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, r, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, r, busy
    );
endinterface

// File: rtl/mod47_mul_seq.sv
// Mod-47 multiplier that reuses one 3x3 digit multiplier over four steps,
// accumulating weighted partial products modulo 47.
module mod47_mul_seq #(
    parameter int BYPASS_ZERO = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mod47_mul_seq_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_a;
    logic [5:0]  r_b;
    logic [5:0]  r_acc;
    logic [1:0]  r_step;
    logic [5:0]  r_r;

    logic [5:0]  w_a_red;
    logic [5:0]  w_b_red;
    logic        w_bypass;
    logic [5:0]  w_pp;
    logic [4:0]  w_wt;
    logic [9:0]  w_prod;
    logic [5:0]  w_term;
    logic [6:0]  w_sum;
    logic [5:0]  w_acc_next;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_busy;

    function automatic logic [5:0] reduce_in(input logic [5:0] x);
        return (x >= 6'd47) ? x - 6'd47 : x;
    endfunction

    // Binary-weighted conditional subtraction of 47*16..47*1; valid for x < 47*32.
    function automatic logic [5:0] mod47_10(input logic [9:0] x);
        logic [9:0] t;
        t = x;
        if (t >= 10'd752) t = t - 10'd752;
        if (t >= 10'd376) t = t - 10'd376;
        if (t >= 10'd188) t = t - 10'd188;
        if (t >= 10'd94)  t = t - 10'd94;
        if (t >= 10'd47)  t = t - 10'd47;
        return t[5:0];
    endfunction

    assign w_a_red  = reduce_in(bus.a);
    assign w_b_red  = reduce_in(bus.b);
    assign w_bypass = (BYPASS_ZERO != 0) && ((w_a_red == 6'd0) || (w_b_red == 6'd0));

    always_comb begin
        w_pp = 6'd0;
        w_wt = 5'd0;
        case (r_step)
            2'd0: begin w_pp = 6'(r_a[2:0] * r_b[2:0]); w_wt = 5'd1;  end
            2'd1: begin w_pp = 6'(r_a[2:0] * r_b[5:3]); w_wt = 5'd8;  end
            2'd2: begin w_pp = 6'(r_a[5:3] * r_b[2:0]); w_wt = 5'd8;  end
            default: begin w_pp = 6'(r_a[5:3] * r_b[5:3]); w_wt = 5'd17; end
        endcase
    end

    assign w_prod     = 10'(w_pp) * 10'(w_wt);
    assign w_term     = mod47_10(w_prod);
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_term};
    assign w_acc_next = (w_sum >= 7'd47) ? 6'(w_sum - 7'd47) : w_sum[5:0];

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_next = w_bypass ? S_DONE : S_CALC;
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_step == 2'd3) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= 6'd0;
            r_b     <= 6'd0;
            r_acc   <= 6'd0;
            r_step  <= 2'd0;
            r_r     <= 6'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a    <= w_a_red;
                        r_b    <= w_b_red;
                        r_acc  <= 6'd0;
                        r_step <= 2'd0;
                        if (w_bypass) r_r <= 6'd0;
                    end
                end
                S_CALC: begin
                    r_acc  <= w_acc_next;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) r_r <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.r         = r_r;

endmodule

// File: doc/mod47_mul_seq.md
Name: mod47_mul_seq

Overview:
Sequenced mod-47 multiplier for 6-bit residue operands. It reuses a single 3x3-bit partial-product multiplier over four cycles, one digit pair per cycle, and accumulates the weighted partial products modulo 47. It sits between an operand producer and a result consumer in the mod-47 arithmetic path, with valid/ready handshakes on both sides.

Parameters:
BYPASS_ZERO, 1, when 1 a zero operand (after reduction) skips the CALC steps and the block returns 0 one cycle after accept; when 0 it always runs four CALC steps.

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  6  operand A, 0..63; values 47..63 are reduced by subtracting 47 at capture
b  input  6  operand B, same rule as a
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  consumer accepts result
r  output  6  (a*b) mod 47, range 0..46
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: if rst_n is low at a clock edge, the next state is IDLE, regardless of current state (this aborts any operation in flight).
  - r=0, out_valid=0, busy=0, in_ready=1.
  - Accumulator, step counter and operand registers are cleared to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a'=(a>=47 ? a-47 : a) and b' (same rule) and clear the accumulator.
  - If BYPASS_ZERO=1 and (a'==0 or b'==0): go to DONE with r=0.
  - Otherwise go to CALC with step=0.
- CALC: one digit product per cycle, using the 3-bit digits a'=ah*8+al and b'=bh*8+bl.
  - Step 0: pp=al*bl, w=1.
  - Step 1: pp=al*bh, w=8.
  - Step 2: pp=ah*bl, w=8.
  - Step 3: pp=ah*bh, w=17 (64 mod 47).
  - Each step: term=(pp*w) mod 47; acc_next=acc+term, minus 47 if the sum is >=47. acc always stays within 0..46.
  - pp is 0..49 (6 bits); pp*w is at most 833 (10 bits). The mod-47 reduction is combinational inside the block; it is not a divider.
  - After step 3, r<=acc_next and the state goes to DONE.
  - in_ready=0 throughout; in_valid is ignored.
- DONE:
  - out_valid=1. r holds stable until the handshake completes.
  - On out_ready: go to IDLE; out_valid drops on the next cycle.
  - There is no same-cycle accept in DONE; in_ready rises in the cycle after the result handshake.
  - Back-pressure (out_ready=0) holds DONE indefinitely.
- Latency, counted from the accept edge E0:
  - Normal path: CALC steps occupy edges E1..E4; DONE is entered at E4, so out_valid is high 4 cycles after accept.
  - Zero bypass: out_valid is high 1 cycle after accept.
  - Throughput: at most one operation per 6 cycles with out_ready held high.
- r keeps its last value in IDLE and CALC. It is only updated on entry to DONE.
- busy=1 in CALC and DONE; busy=0 in IDLE.
- Changes to a and b after capture have no effect on the operation in flight.

Test Plan:
- Reset, then a=5, b=7 with in_valid for one cycle -> in_ready drops; out_valid high 4 cycles after accept with r=35; out_ready=1 -> IDLE, in_ready=1 the next cycle.
- a=46, b=46 -> r=1. Internal acc after steps 0..3 is 36, 41, 46, 1, which exercises the subtract-47 wrap.
- a=50, b=9 -> a' reduced to 3 -> r=27. a=63, b=63 -> a'=b'=16 -> r=256 mod 47=21.
- BYPASS_ZERO=1, a=0, b=33 -> out_valid 1 cycle after accept, r=0. BYPASS_ZERO=0, same stimulus -> 4-cycle latency, r=0.
- a=10, b=20 with out_ready=0 for 10 cycles -> out_valid stays high and r=12 stays stable; in_valid pulsed during this window is not accepted; out_ready=1 -> completes.
- Start a=46, b=46, assert rst_n=0 during CALC step 2 -> next cycle state is IDLE, out_valid=0, r=0, busy=0; a new op a=2, b=3 then returns r=6.
